// File: rtl/si5345_spi_pkg.sv
// rtl/si5345_spi_pkg.sv - shared Si5345 SPI command constants and state encoding
// Used by both the SPI master and the slave emulator.
package si5345_spi_pkg;

    localparam logic [7:0] CMD_SET_ADDR  = 8'h00;
    localparam logic [7:0] CMD_WRITE     = 8'h40;
    localparam logic [7:0] CMD_WRITE_INC = 8'h60;
    localparam logic [7:0] CMD_READ      = 8'h80;
    localparam logic [7:0] CMD_READ_INC  = 8'hA0;

    // Register address of the page register, mirrored on every page.
    localparam logic [7:0] PAGE_ADDR = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_SKIP
    } spi_state_e;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_SET_ADDR) || (cmd == CMD_WRITE) || (cmd == CMD_WRITE_INC) ||
               (cmd == CMD_READ) || (cmd == CMD_READ_INC);
    endfunction

    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_READ_INC);
    endfunction

endpackage

// File: rtl/spi_slave_in_sync.sv
// rtl/spi_slave_in_sync.sv - SPI input synchronizers and edge pulse generation
// Ports: sys_clk/reset_n; cs_n_i, sclk_i, sdi_i raw pins in;
//        cs_fall_o, cs_rise_o, sclk_rise_o, sclk_fall_o one-cycle pulses;
//        sdi_o synchronized data aligned with the edge pulses.
module spi_slave_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic cs_n_i,
    input  logic sclk_i,
    input  logic sdi_i,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic sdi_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
    logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic sdi_q, sdi_d;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_fall_d   = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
        cs_rise_d   = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
        sclk_rise_d = ~sclk_prev_q & sclk_sync_q[SYNC_STAGES-1];
        sclk_fall_d = sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];
        sdi_d       = sdi_sync_q[SYNC_STAGES-1];
    end

    // The cs_n chain resets to 0 ("selected") so a frame already in progress when
    // reset releases never produces a cs fall; only a real high-to-low transition starts a frame.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            sdi_q       <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            cs_fall_q   <= cs_fall_d;
            cs_rise_q   <= cs_rise_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            sdi_q       <= sdi_d;
        end
    end

    assign cs_fall_o   = cs_fall_q;
    assign cs_rise_o   = cs_rise_q;
    assign sclk_rise_o = sclk_rise_q;
    assign sclk_fall_o = sclk_fall_q;
    assign sdi_o       = sdi_q;

endmodule

// File: rtl/si5345_spi_slave_emu.sv
// rtl/si5345_spi_slave_emu.sv - Si5345 paged-register SPI slave emulator
// Ports: sys_clk/reset_n; SPI cs_n_i, sclk_i, sdi_i in, sdo_o/sdo_oe_o out;
//        wr_stb_o/wr_addr_o/wr_data_o commit notification; frame_err_o partial-byte abort pulse;
//        dbg_addr_i/dbg_data_o fabric readback port (1-cycle latency).
module si5345_spi_slave_emu
    import si5345_spi_pkg::*;
#(
    parameter int PAGES       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        cs_n_i,
    input  logic        sclk_i,
    input  logic        sdi_i,
    output logic        sdo_o,
    output logic        sdo_oe_o,
    output logic        wr_stb_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        frame_err_o,
    input  logic [15:0] dbg_addr_i,
    output logic [7:0]  dbg_data_o
);

    localparam int         AW      = $clog2(PAGES * 256);
    localparam logic [8:0] PAGES_L = 9'(PAGES);

    function automatic logic page_ok(input logic [7:0] p);
        return {1'b0, p} < PAGES_L;
    endfunction

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, sdi_s;

    spi_slave_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .cs_n_i      (cs_n_i),
        .sclk_i      (sclk_i),
        .sdi_i       (sdi_i),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .sdi_o       (sdi_s)
    );

    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, cmd_q, cmd_d, page_q, page_d, addr_q, addr_d, tx_q, tx_d;
    logic        first_q, first_d, load_q, load_d;
    logic        sdo_q, sdo_d, sdo_oe_q, sdo_oe_d, wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        dbg_ok_q, dbg_ok_d;

    logic [7:0]  ram [PAGES*256];
    logic [7:0]  ram_a_dout, ram_b_dout;
    logic        ram_we;
    logic [15:0] a_addr;
    logic [7:0]  byte_in, rd_src, tx_byte;

    assign a_addr  = {page_q, addr_q};
    assign byte_in = {shift_q[6:0], sdi_s};

    // Read-first dual-port RAM: both ports see the pre-write contents on a same-cycle write.
    // Port A is read every cycle; a read byte is only consumed on an SCLK fall, several cycles
    // after addr_q/page_q last changed, so the one-cycle lag is harmless.
    always_ff @(posedge sys_clk) begin
        if (ram_we) begin
            ram[a_addr[AW-1:0]] <= byte_in;
        end
        ram_a_dout <= ram[a_addr[AW-1:0]];
        ram_b_dout <= ram[dbg_addr_i[AW-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cmd_d       = cmd_q;
        page_d      = page_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        first_d     = first_q;
        load_d      = load_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        dbg_ok_d    = page_ok(dbg_addr_i[15:8]);
        ram_we      = 1'b0;

        if (addr_q == PAGE_ADDR) begin
            rd_src = page_q;
        end else if (page_ok(page_q)) begin
            rd_src = ram_a_dout;
        end else begin
            rd_src = 8'h00;
        end
        // Plain READ serves only its first data byte; later bytes shift out zeros.
        tx_byte = (cmd_q == CMD_READ && !first_q) ? 8'h00 : rd_src;

        if (cs_rise) begin
            if (state_q != ST_IDLE && bit_cnt_q != 3'd0) begin
                frame_err_d = 1'b1;
            end
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
            sdo_oe_d  = 1'b0;
            load_d    = 1'b0;
        end else if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            first_d   = 1'b1;
            load_d    = 1'b0;
        end else if (state_q != ST_IDLE && sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_CMD) begin
                    cmd_d   = byte_in;
                    first_d = 1'b1;
                    if (cmd_known(byte_in)) begin
                        state_d = ST_DATA;
                        load_d  = cmd_is_read(byte_in);
                    end else begin
                        state_d = ST_SKIP;
                    end
                end else if (state_q == ST_DATA) begin
                    first_d = 1'b0;
                    if (cmd_q == CMD_SET_ADDR) begin
                        if (first_q) begin
                            addr_d = byte_in;
                        end
                    end else if (cmd_q == CMD_WRITE_INC || (cmd_q == CMD_WRITE && first_q)) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = a_addr;
                        wr_data_d = byte_in;
                        if (addr_q == PAGE_ADDR) begin
                            page_d = byte_in;
                        end else begin
                            ram_we = page_ok(page_q);
                        end
                        if (cmd_q == CMD_WRITE_INC) begin
                            addr_d = addr_q + 8'd1;
                        end
                    end else if (cmd_is_read(cmd_q)) begin
                        load_d = 1'b1;
                        if (cmd_q == CMD_READ_INC) begin
                            addr_d = addr_q + 8'd1;
                        end
                    end
                end
            end
        end else if (state_q == ST_DATA && cmd_is_read(cmd_q) && sclk_fall) begin
            if (load_q) begin
                sdo_d    = tx_byte[7];
                tx_d     = {tx_byte[6:0], 1'b0};
                sdo_oe_d = 1'b1;
                load_d   = 1'b0;
            end else begin
                sdo_d = tx_q[7];
                tx_d  = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            cmd_q       <= 8'h00;
            page_q      <= 8'h00;
            addr_q      <= 8'h00;
            tx_q        <= 8'h00;
            first_q     <= 1'b0;
            load_q      <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            dbg_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            page_q      <= page_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            first_q     <= first_d;
            load_q      <= load_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            dbg_ok_q    <= dbg_ok_d;
        end
    end

    assign sdo_o       = sdo_q;
    assign sdo_oe_o    = sdo_oe_q;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_err_o = frame_err_q;
    assign dbg_data_o  = dbg_ok_q ? ram_b_dout : 8'h00;

endmodule

// File: tb/tb_si5345_spi_slave_emu.sv
// tb/tb_si5345_spi_slave_emu.sv - self-checking bench for si5345_spi_slave_emu
module tb_si5345_spi_slave_emu;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        cs_n_i, sclk_i, sdi_i;
    logic        sdo_o, sdo_oe_o, wr_stb_o, frame_err_o;
    logic [15:0] wr_addr_o, dbg_addr_i;
    logic [7:0]  wr_data_o, dbg_data_o;

    always #5 sys_clk = ~sys_clk;

    si5345_spi_slave_emu #(.PAGES(16), .SYNC_STAGES(2)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .cs_n_i      (cs_n_i),
        .sclk_i      (sclk_i),
        .sdi_i       (sdi_i),
        .sdo_o       (sdo_o),
        .sdo_oe_o    (sdo_oe_o),
        .wr_stb_o    (wr_stb_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .frame_err_o (frame_err_o),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  txb [4];
    logic [7:0]  rxb [4];
    logic [7:0]  oeb [4];
    logic [23:0] stb_q[$];
    logic [7:0]  stb_dbg;
    int          ferr_cnt = 0;

    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (wr_stb_o) begin
                stb_q.push_back({wr_addr_o, wr_data_o});
                stb_dbg = dbg_data_o;
            end
            if (frame_err_o) ferr_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        sdi_i = b;
        cyc(8);
        sclk_i = 1'b1;
        r  = sdo_o;
        oe = sdo_oe_o;
        cyc(8);
        sclk_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r, o);
            rx[i] = r;
            oe[i] = o;
        end
    endtask

    task automatic frame(input int nb, input int extra);
        logic [7:0] t;
        logic r, o;
        cs_n_i = 1'b0;
        cyc(8);
        for (int b = 0; b < nb; b++) spi_byte(txb[b], rxb[b], oeb[b]);
        t = txb[nb];
        for (int i = 0; i < extra; i++) spi_bit(t[7-i], r, o);
        cyc(8);
        cs_n_i = 1'b1;
        cyc(12);
    endtask

    task automatic set_addr(input logic [7:0] a);
        txb[0] = 8'h00; txb[1] = a; frame(2, 0);
    endtask

    task automatic write_cur(input logic [7:0] d);
        txb[0] = 8'h40; txb[1] = d; frame(2, 0);
    endtask

    task automatic set_page(input logic [7:0] p);
        set_addr(8'h01);
        write_cur(p);
    endtask

    task automatic read_cur();
        txb[0] = 8'h80; txb[1] = 8'h00; frame(2, 0);
    endtask

    function automatic logic [23:0] stb_at(input int i);
        return (stb_q.size() > i) ? stb_q[i] : 24'hxxxxxx;
    endfunction

    typedef struct {
        bit         is_rd;
        logic [7:0] page;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];
    int   ferr0;
    logic r, o;
    logic [7:0] rx8, oe8;

    initial begin
        vecs[0] = '{1'b0, 8'h0B, 8'h24, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 8'h0B, 8'h24, 8'h00, 8'h5A};
        vecs[2] = '{1'b0, 8'h00, 8'h24, 8'hC7, 8'hC7};
        vecs[3] = '{1'b1, 8'h00, 8'h24, 8'h00, 8'hC7};
        vecs[4] = '{1'b0, 8'h14, 8'h10, 8'h99, 8'h00};
        vecs[5] = '{1'b1, 8'h14, 8'h10, 8'h00, 8'h00};
        vecs[6] = '{1'b1, 8'h0B, 8'h01, 8'h00, 8'h0B};
        vecs[7] = '{1'b0, 8'h0F, 8'hFF, 8'h3C, 8'h3C};
        vecs[8] = '{1'b1, 8'h0F, 8'hFF, 8'h00, 8'h3C};
        vecs[9] = '{1'b1, 8'h0B, 8'h24, 8'h00, 8'h5A};

        reset_n = 1'b0; cs_n_i = 1'b1; sclk_i = 1'b0; sdi_i = 1'b0; dbg_addr_i = 16'h0000;
        cyc(4);
        chk("rst_sdo", {31'd0, sdo_o}, 32'd0);
        chk("rst_sdo_oe", {31'd0, sdo_oe_o}, 32'd0);
        chk("rst_wr_stb", {31'd0, wr_stb_o}, 32'd0);
        chk("rst_wr_addr", {16'd0, wr_addr_o}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
        chk("rst_dbg_data", {24'd0, dbg_data_o}, 32'd0);
        reset_n = 1'b1;
        cyc(10);

        for (int v = 0; v < 10; v++) begin
            set_page(vecs[v].page);
            set_addr(vecs[v].addr);
            if (!vecs[v].is_rd) begin
                stb_q.delete();
                write_cur(vecs[v].data);
                chk($sformatf("v%0d_stb_cnt", v), stb_q.size(), 32'd1);
                chk($sformatf("v%0d_stb", v), {8'd0, stb_at(0)}, {8'd0, vecs[v].page, vecs[v].addr, vecs[v].data});
                dbg_addr_i = {vecs[v].page, vecs[v].addr};
                cyc(2);
                chk($sformatf("v%0d_dbg", v), {24'd0, dbg_data_o}, {24'd0, vecs[v].exp});
            end else begin
                read_cur();
                chk($sformatf("v%0d_rd", v), {24'd0, rxb[1]}, {24'd0, vecs[v].exp});
                chk($sformatf("v%0d_oe_cmd", v), {24'd0, oeb[0]}, 32'h00);
                chk($sformatf("v%0d_oe_data", v), {24'd0, oeb[1]}, 32'hFF);
                chk($sformatf("v%0d_oe_end", v), {31'd0, sdo_oe_o}, 32'd0);
            end
        end

        // WRITE_INC across the in-page wrap, then READ_INC back.
        set_page(8'h02);
        set_addr(8'hFE);
        stb_q.delete();
        txb[0] = 8'h60; txb[1] = 8'h11; txb[2] = 8'h22; txb[3] = 8'h33;
        frame(4, 0);
        chk("winc_cnt", stb_q.size(), 32'd3);
        chk("winc_0", {8'd0, stb_at(0)}, 32'h0002FE11);
        chk("winc_1", {8'd0, stb_at(1)}, 32'h0002FF22);
        chk("winc_2", {8'd0, stb_at(2)}, 32'h00020033);
        set_addr(8'hFE);
        txb[0] = 8'hA0; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00;
        frame(4, 0);
        chk("rinc_0", {24'd0, rxb[1]}, 32'h11);
        chk("rinc_1", {24'd0, rxb[2]}, 32'h22);
        chk("rinc_2", {24'd0, rxb[3]}, 32'h33);

        // Abort after 12 bits of a WRITE frame.
        set_page(8'h00);
        set_addr(8'h50);
        write_cur(8'h77);
        ferr0 = ferr_cnt;
        stb_q.delete();
        txb[0] = 8'h40; txb[1] = 8'hAB;
        frame(1, 4);
        chk("abort_no_stb", stb_q.size(), 32'd0);
        chk("abort_ferr", ferr_cnt - ferr0, 32'd1);
        dbg_addr_i = 16'h0050;
        cyc(2);
        chk("abort_ram", {24'd0, dbg_data_o}, 32'h77);

        // Unknown command is skipped entirely.
        ferr0 = ferr_cnt;
        txb[0] = 8'hC3; txb[1] = 8'hFF;
        frame(2, 0);
        chk("unk_no_stb", stb_q.size(), 32'd0);
        chk("unk_oe", {16'd0, oeb[0], oeb[1]}, 32'h0000);
        chk("unk_no_ferr", ferr_cnt - ferr0, 32'd0);

        // Plain WRITE commits only its first byte; plain READ returns zeros after the first.
        set_addr(8'h60);
        stb_q.delete();
        txb[0] = 8'h40; txb[1] = 8'h12; txb[2] = 8'h34;
        frame(3, 0);
        chk("wr1_cnt", stb_q.size(), 32'd1);
        chk("wr1_stb", {8'd0, stb_at(0)}, 32'h00006012);
        txb[0] = 8'h80; txb[1] = 8'h00; txb[2] = 8'h00;
        frame(3, 0);
        chk("rd1_b0", {24'd0, rxb[1]}, 32'h12);
        chk("rd1_b1", {24'd0, rxb[2]}, 32'h00);

        // Fabric read of the address being committed returns the old byte.
        dbg_addr_i = 16'h0060;
        cyc(2);
        stb_q.delete();
        write_cur(8'h56);
        chk("coll_old", {24'd0, stb_dbg}, 32'h12);
        chk("coll_new", {24'd0, dbg_data_o}, 32'h56);

        // Page register via SET_ADDR 0x01 + WRITE.
        stb_q.delete();
        set_addr(8'h01);
        write_cur(8'h05);
        chk("pg_stb", {8'd0, stb_at(0)}, 32'h00000105);
        read_cur();
        chk("pg_rd", {24'd0, rxb[1]}, 32'h05);

        // Reset in the middle of a READ frame.
        set_page(8'h00);
        set_addr(8'h24);
        ferr0 = ferr_cnt;
        cs_n_i = 1'b0;
        cyc(8);
        spi_byte(8'h80, rx8, oe8);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
        chk("mid_oe_on", {31'd0, sdo_oe_o}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_oe", {31'd0, sdo_oe_o}, 32'd0);
        cyc(3);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) spi_bit(1'b0, r, o);
        cyc(8);
        cs_n_i = 1'b1;
        cyc(12);
        chk("mid_no_ferr", ferr_cnt - ferr0, 32'd0);
        set_addr(8'h01);
        read_cur();
        chk("mid_page0", {24'd0, rxb[1]}, 32'h00);
        set_addr(8'h24);
        read_cur();
        chk("mid_ram_kept", {24'd0, rxb[1]}, 32'hC7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
